// File: rtl/sift_detection_fifo_buffer_param.sv
// Parametrised synchronous FIFO that buffers detection-stage words between
// SIFT pipeline stages. It supports a normal registered read or a show-ahead
// read, has almost-full/almost-empty thresholds, sticky overflow/underflow
// flags and a synchronous flush.
module sift_detection_fifo_buffer_param #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 15,
  parameter int AF_THRESH  = (2 ** DEPTH_LOG2) - 4,
  parameter int AE_THRESH  = 4,
  parameter bit SHOW_AHEAD = 1'b0
) (
  input  logic                  iclk,
  input  logic                  ireset,
  input  logic                  iclear,
  input  logic                  iwrite_en,
  input  logic                  iread_en,
  input  logic [DATA_W-1:0]     idata,
  output logic                  odata_en,
  output logic [DATA_W-1:0]     odata,
  output logic [DEPTH_LOG2:0]   ousedw,
  output logic                  ofull,
  output logic                  oempty,
  output logic                  oalmost_full,
  output logic                  oalmost_empty,
  output logic                  ooverflow,
  output logic                  ounderflow
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = DEPTH[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0]   AF_CNT    = AF_THRESH[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0]   AE_CNT    = AE_THRESH[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

  // Threshold ordering must hold or the level flags become meaningless.
  if (!((AE_THRESH >= 0) && (AE_THRESH < AF_THRESH) && (AF_THRESH <= DEPTH))) begin : g_bad_thresholds
    $error("sift_detection_fifo_buffer_param: need 0 <= AE_THRESH < AF_THRESH <= DEPTH");
  end

  logic [DATA_W-1:0]     mem [DEPTH];

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [DATA_W-1:0]     odata_q, odata_d;
  logic                  odata_en_q, odata_en_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;

  logic                  full, empty;
  logic                  wr_acc, rd_acc;

  // Level flags come straight from the registered count, so they all move
  // together one edge after the access that changed the count.
  assign full          = (count_q == DEPTH_CNT);
  assign empty         = (count_q == '0);
  assign ofull         = full;
  assign oempty        = empty;
  assign oalmost_full  = (count_q >= AF_CNT);
  assign oalmost_empty = (count_q <= AE_CNT);
  assign ousedw        = count_q;
  assign ooverflow     = ovf_q;
  assign ounderflow    = udf_q;

  // Acceptance uses the registered flags: a simultaneous read never makes
  // room for a write when full, and a write never feeds a read when empty.
  assign wr_acc = iwrite_en & ~full;
  assign rd_acc = iread_en & ~empty;

  // Show-ahead presents the head word whenever something is stored; the
  // registered copy keeps odata stable while the FIFO is empty.
  assign odata    = SHOW_AHEAD ? (empty ? odata_q : mem[rd_ptr_q]) : odata_q;
  assign odata_en = SHOW_AHEAD ? ~empty : odata_en_q;

  // Storage write port; flushed or reset cycles never touch the array.
  always_ff @(posedge iclk) begin
    if (wr_acc && !iclear && !ireset) begin
      mem[wr_ptr_q] <= idata;
    end
  end

  // Next-state: flush beats normal traffic and ignores that cycle's requests.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    odata_d    = odata_q;
    odata_en_d = 1'b0;
    ovf_d      = ovf_q;
    udf_d      = udf_q;
    if (iclear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (iwrite_en && full) begin
        ovf_d = 1'b1;
      end
      if (iread_en && empty) begin
        udf_d = 1'b1;
      end
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (rd_acc) begin
        rd_ptr_d   = rd_ptr_q + PTR_ONE;
        odata_d    = mem[rd_ptr_q];
        odata_en_d = 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Control and output registers with synchronous active-high reset.
  always_ff @(posedge iclk) begin
    if (ireset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      odata_q    <= '0;
      odata_en_q <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      odata_q    <= odata_d;
      odata_en_q <= odata_en_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

endmodule

// File: tb/tb_sift_detection_fifo_buffer_param.sv
// Bench for sift_detection_fifo_buffer_param: a normal-read and a show-ahead
// instance share one stimulus stream and are checked every cycle against a
// queue-based model, plus hand-computed expectations at key points.
module tb_sift_detection_fifo_buffer_param;

  localparam int DW    = 8;
  localparam int DL2   = 3;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 1;

  logic          iclk = 1'b0;
  logic          ireset = 1'b1;
  logic          iclear = 1'b0;
  logic          iwrite_en = 1'b0;
  logic          iread_en = 1'b0;
  logic [DW-1:0] idata = '0;

  logic          odata_en, sa_odata_en;
  logic [DW-1:0] odata, sa_odata;
  logic [DL2:0]  ousedw, sa_ousedw;
  logic          ofull, oempty, oalmost_full, oalmost_empty, ooverflow, ounderflow;
  logic          sa_ofull, sa_oempty, sa_oalmost_full, sa_oalmost_empty, sa_ooverflow, sa_ounderflow;

  always #5 iclk = ~iclk;

  sift_detection_fifo_buffer_param #(
    .DATA_W(DW), .DEPTH_LOG2(DL2), .AF_THRESH(AF), .AE_THRESH(AE), .SHOW_AHEAD(1'b0)
  ) dut (
    .iclk(iclk), .ireset(ireset), .iclear(iclear), .iwrite_en(iwrite_en),
    .iread_en(iread_en), .idata(idata), .odata_en(odata_en), .odata(odata),
    .ousedw(ousedw), .ofull(ofull), .oempty(oempty), .oalmost_full(oalmost_full),
    .oalmost_empty(oalmost_empty), .ooverflow(ooverflow), .ounderflow(ounderflow)
  );

  sift_detection_fifo_buffer_param #(
    .DATA_W(DW), .DEPTH_LOG2(DL2), .AF_THRESH(AF), .AE_THRESH(AE), .SHOW_AHEAD(1'b1)
  ) dut_sa (
    .iclk(iclk), .ireset(ireset), .iclear(iclear), .iwrite_en(iwrite_en),
    .iread_en(iread_en), .idata(idata), .odata_en(sa_odata_en), .odata(sa_odata),
    .ousedw(sa_ousedw), .ofull(sa_ofull), .oempty(sa_oempty), .oalmost_full(sa_oalmost_full),
    .oalmost_empty(sa_oalmost_empty), .ooverflow(sa_ooverflow), .ounderflow(sa_ounderflow)
  );

  // Behavioural model state.
  logic [DW-1:0] mq[$];
  logic          m_ovf = 1'b0;
  logic          m_udf = 1'b0;
  logic [DW-1:0] m_odata = '0;
  logic          m_odata_en = 1'b0;
  bit            chk_en = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
    end
  endfunction

  // Advance the model by one clock edge from the inputs that were applied.
  task automatic model_edge(input logic w, input logic r, input logic c, input logic rs,
                            input logic [DW-1:0] d);
    int sz;
    sz = mq.size();
    if (rs) begin
      mq.delete();
      m_ovf = 1'b0; m_udf = 1'b0; m_odata = '0; m_odata_en = 1'b0;
    end else if (c) begin
      mq.delete();
      m_ovf = 1'b0; m_udf = 1'b0; m_odata_en = 1'b0;
    end else begin
      if (w && sz == DEPTH) m_ovf = 1'b1;
      if (r && sz == 0)     m_udf = 1'b1;
      if (r && sz != 0) begin
        m_odata = mq.pop_front();
        m_odata_en = 1'b1;
      end else begin
        m_odata_en = 1'b0;
      end
      if (w && sz != DEPTH) mq.push_back(d);
    end
  endtask

  // Apply one cycle of stimulus; returns at the following falling edge.
  task automatic step(input logic w, input logic r, input logic c, input logic rs,
                      input logic [DW-1:0] d);
    iwrite_en = w; iread_en = r; iclear = c; ireset = rs; idata = d;
    @(posedge iclk);
    model_edge(w, r, c, rs, d);
    chk_en = 1'b1;
    @(negedge iclk);
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge iclk) begin
    if (chk_en) begin
      check("usedw",      int'(ousedw),        mq.size());
      check("full",       int'(ofull),         int'(mq.size() == DEPTH));
      check("empty",      int'(oempty),        int'(mq.size() == 0));
      check("almost_full",  int'(oalmost_full),  int'(mq.size() >= AF));
      check("almost_empty", int'(oalmost_empty), int'(mq.size() <= AE));
      check("overflow",   int'(ooverflow),     int'(m_ovf));
      check("underflow",  int'(ounderflow),    int'(m_udf));
      check("odata_en",   int'(odata_en),      int'(m_odata_en));
      check("odata",      int'(odata),         int'(m_odata));
      check("sa_usedw",   int'(sa_ousedw),     mq.size());
      check("sa_overflow",  int'(sa_ooverflow),  int'(m_ovf));
      check("sa_underflow", int'(sa_ounderflow), int'(m_udf));
      check("sa_odata_en",  int'(sa_odata_en),   int'(mq.size() != 0));
      if (mq.size() != 0) check("sa_odata", int'(sa_odata), int'(mq[0]));
    end
  end

  initial begin
    int pw, pr;
    // Reset state.
    step(0, 0, 0, 1, 8'h00);
    step(0, 0, 0, 1, 8'h00);
    check("rst_usedw", int'(ousedw), 0);
    check("rst_empty", int'(oempty), 1);
    check("rst_aempty", int'(oalmost_empty), 1);
    check("rst_odata", int'(odata), 0);
    check("rst_odata_en", int'(odata_en), 0);

    // Fill 0x10..0x17.
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 0, 0, 8'(8'h10 + i));
      check("fill_usedw", int'(ousedw), i + 1);
      check("fill_afull", int'(oalmost_full), int'(i + 1 >= 6));
    end
    check("fill_full", int'(ofull), 1);
    check("model_size8", mq.size(), 8);

    // Write while full: rejected, sticky overflow.
    step(1, 0, 0, 0, 8'hAA);
    check("ovf_usedw", int'(ousedw), 8);
    check("ovf_flag", int'(ooverflow), 1);

    // Drain in order.
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0, 0, 8'h00);
      check("drain_odata", int'(odata), 8'h10 + i);
      check("drain_en", int'(odata_en), 1);
    end
    check("drain_empty", int'(oempty), 1);
    check("ovf_sticky", int'(ooverflow), 1);

    // Read while empty.
    step(0, 1, 0, 0, 8'h00);
    check("udf_flag", int'(ounderflow), 1);
    check("udf_en", int'(odata_en), 0);
    check("udf_odata_hold", int'(odata), 8'h17);

    // Simultaneous read/write at count 4 across pointer wrap.
    step(0, 0, 1, 0, 8'h00);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 8'(8'h40 + i));
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 0, 0, 8'(8'h44 + i));
      check("simul_usedw", int'(ousedw), 4);
      check("simul_odata", int'(odata), 8'h40 + i);
    end
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 8'h00);
    check("simul_last", int'(odata), 8'h57);

    // Empty boundary: write and read together into an empty FIFO.
    step(0, 0, 1, 0, 8'h00);
    step(1, 1, 0, 0, 8'h5C);
    check("eb_usedw", int'(ousedw), 1);
    check("eb_udf", int'(ounderflow), 1);
    check("eb_en", int'(odata_en), 0);
    check("sa_eb_odata", int'(sa_odata), 8'h5C);
    step(0, 1, 0, 0, 8'h00);
    check("eb_read", int'(odata), 8'h5C);

    // Show-ahead: write into empty then pop.
    step(0, 0, 1, 0, 8'h00);
    step(1, 0, 0, 0, 8'h3E);
    check("sa_odata", int'(sa_odata), 8'h3E);
    check("sa_en", int'(sa_odata_en), 1);
    step(0, 1, 0, 0, 8'h00);
    check("sa_pop_en", int'(sa_odata_en), 0);
    check("sa_pop_empty", int'(sa_oempty), 1);

    // Flush at count 5 with overflow set; write in flush cycle ignored.
    for (int i = 0; i < 9; i++) step(1, 0, 0, 0, 8'(8'h60 + i));
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 8'h00);
    check("pre_flush_usedw", int'(ousedw), 5);
    check("pre_flush_ovf", int'(ooverflow), 1);
    step(1, 0, 1, 0, 8'hEE);
    check("flush_usedw", int'(ousedw), 0);
    check("flush_empty", int'(oempty), 1);
    check("flush_ovf", int'(ooverflow), 0);
    check("flush_odata_hold", int'(odata), 8'h62);

    // Reset mid-drain.
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 8'(8'h70 + i));
    step(0, 1, 0, 0, 8'h00);
    step(0, 1, 0, 1, 8'h00);
    check("rst2_usedw", int'(ousedw), 0);
    check("rst2_odata", int'(odata), 0);
    check("rst2_en", int'(odata_en), 0);
    check("rst2_aempty", int'(oalmost_empty), 1);
    check("rst2_afull", int'(oalmost_full), 0);

    // Randomized traffic with varying read/write bias.
    for (int blk = 0; blk < 12; blk++) begin
      pw = $urandom_range(20, 80);
      pr = $urandom_range(20, 80);
      for (int i = 0; i < 200; i++) begin
        step(($urandom_range(0, 99) < pw), ($urandom_range(0, 99) < pr),
             ($urandom_range(0, 63) == 0), ($urandom_range(0, 199) == 0),
             8'($urandom_range(0, 255)));
      end
    end
    step(0, 0, 0, 0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
